// File: rtl/mem_bus_unit.sv
// Bus-side responder for rec/wr commands: holds AR, MDR and IR, and runs
// single-word read/write transactions with an ack timeout. stall holds the
// beat sequencer while a transaction is outstanding.
module mem_bus_unit #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beat,
  input  logic [1:0]    rec,
  input  logic          wr,
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] sr_val,
  input  logic [DW-1:0] alu_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          stall,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ar;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          busy;
  logic          tmo_hit;

  // Address bits of sr_val above AW are not used as an address.
  if (DW > AW) begin : g_sr_hi
    logic unused_sr_hi;
    assign unused_sr_hi = ^sr_val[DW-1:AW];
  end

  assign accept   = beat && (state == IDLE);
  assign busy     = (state != IDLE);
  // This wait cycle would bring the counter to TIMEOUT; ack still wins.
  assign tmo_hit  = busy && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
  assign mem_addr = ar;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: write has priority over rec; only odd rec codes start a read
  always_comb begin
    state_nxt = state;
    stall     = busy;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!wr)         state_nxt = WR_WAIT;
          else if (rec[0]) state_nxt = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registers, bus outputs and the saturating wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ar        <= '0;
      mdr       <= '0;
      ir        <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      bus_err   <= 1'b0;
    end else if (accept) begin
      if (!wr) begin
        // Write goes to the AR already held; rec is ignored.
        mem_wdata <= alu_out;
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        wait_cnt  <= '0;
      end else begin
        case (rec)
          2'b01: begin
            ar       <= pc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
          end
          2'b11: begin
            ar       <= sr_val[AW-1:0];
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
          end
          2'b10:   ir <= mdr;
          default: ;
        endcase
      end
    end else if (busy) begin
      if (mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == RD_WAIT) mdr <= mem_rdata;
      end else if (tmo_hit) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        bus_err  <= 1'b1;
        wait_cnt <= CW'(TIMEOUT);
        if (state == RD_WAIT) mdr <= '1;
      end else if (wait_cnt != CW'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed + randomized check of mem_bus_unit against a transaction-level
// model (AR/MDR/IR/bus_err tracked per command, ack delay decides outcome).
module tb_mem_bus_unit;
  localparam int DW = 16, AW = 16, TIMEOUT = 15;

  logic          clk = 1'b0, rst = 1'b1, beat = 1'b0, wr = 1'b1, mem_ack = 1'b0;
  logic [1:0]    rec = 2'b00;
  logic [AW-1:0] pc = '0;
  logic [DW-1:0] sr_val = '0, alu_out = '0, mem_rdata = '0;
  logic          mem_req, mem_we, stall, bus_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, ir, mdr;

  int checks = 0, errors = 0;

  // reference state
  logic [AW-1:0] m_ar;
  logic [DW-1:0] m_mdr, m_ir;
  logic          m_err;

  mem_bus_unit #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .beat(beat), .rec(rec), .wr(wr), .pc(pc),
    .sr_val(sr_val), .alu_out(alu_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ir(ir), .mdr(mdr), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ar = '0; m_mdr = '0; m_ir = '0; m_err = 1'b0;
  endtask

  // Issue one command on a beat; dly = wait cycles before ack (>=TIMEOUT: none).
  // inject drops a stray beat into the first busy cycle.
  task automatic cmd(input logic [1:0] r, input logic w, input logic [AW-1:0] p,
                     input logic [DW-1:0] s, input logic [DW-1:0] a, input int dly,
                     input logic [DW-1:0] rd, input bit inject);
    bit            is_wr, is_rd;
    int            ncyc;
    logic [AW-1:0] addr;
    is_wr = !w;
    is_rd = w && r[0];
    if (is_rd) m_ar = r[1] ? s[AW-1:0] : p;
    addr = m_ar;
    beat = 1'b1; rec = r; wr = w; pc = p; sr_val = s; alu_out = a;
    step();
    beat = 1'b0; rec = 2'b00; wr = 1'b1;
    if (!is_wr && !is_rd) begin
      if (r == 2'b10) m_ir = m_mdr;
      chk("idle_req", mem_req, 0);
      chk("idle_stall", stall, 0);
      chk("ir", ir, m_ir);
      chk("mdr_idle", mdr, m_mdr);
      return;
    end
    ncyc = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
    for (int n = 0; n < ncyc; n++) begin
      chk("busy_stall", stall, 1);
      chk("busy_req", mem_req, 1);
      chk("addr", mem_addr, addr);
      chk("we", mem_we, is_wr);
      if (is_wr) chk("wdata", mem_wdata, a);
      if (n == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
      if (inject && n == 0) begin
        beat = 1'b1; rec = 2'b01; pc = 16'h0099; wr = 1'($urandom_range(0, 1));
      end
      step();
      mem_ack = 1'b0; beat = 1'b0; rec = 2'b00; wr = 1'b1; mem_rdata = DW'($urandom);
    end
    if (dly >= TIMEOUT) begin
      m_err = 1'b1;
      if (is_rd) m_mdr = '1;
    end else if (is_rd) begin
      m_mdr = rd;
    end
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("mdr", mdr, m_mdr);
    chk("bus_err", bus_err, m_err);
    chk("ir_keep", ir, m_ir);
  endtask

  initial begin
    model_reset();
    // T1: reset
    rst = 1'b1; step(); step();
    chk("rst_ir", ir, 0); chk("rst_mdr", mdr, 0); chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0); chk("rst_err", bus_err, 0);
    rst = 1'b0;
    // stray ack while idle
    mem_ack = 1'b1; mem_rdata = 16'hAAAA; step(); mem_ack = 1'b0;
    chk("late_ack_mdr", mdr, 0); chk("late_ack_stall", stall, 0);
    // T2: read then IR load
    cmd(2'b01, 1'b1, 16'h0010, 16'h0, 16'h0, 1, 16'h1234, 1'b0);
    cmd(2'b10, 1'b1, 16'h0, 16'h0, 16'h0, 0, 16'h0, 1'b0);
    chk("t2_ir", ir, 16'h1234);
    // minimum latency
    cmd(2'b01, 1'b1, 16'h0020, 16'h0, 16'h0, 0, 16'h5555, 1'b0);
    // T3: write uses pre-beat AR, rec ignored
    cmd(2'b01, 1'b1, 16'h0040, 16'h0, 16'h0, 0, 16'h0777, 1'b0);
    cmd(2'b01, 1'b0, 16'h0123, 16'h0, 16'hBEEF, 2, 16'h0, 1'b0);
    cmd(2'b00, 1'b0, 16'h0, 16'h0, 16'h1111, 0, 16'h0, 1'b0);
    cmd(2'b10, 1'b1, 16'h0, 16'h0, 16'h0, 0, 16'h0, 1'b0);
    chk("t3_ir", ir, 16'h0777);
    // ack on the last wait cycle beats the timeout
    cmd(2'b01, 1'b1, 16'h0050, 16'h0, 16'h0, TIMEOUT - 1, 16'h2222, 1'b0);
    chk("ack_wins_err", bus_err, 0);
    // T4: timeout
    cmd(2'b11, 1'b1, 16'h0777, 16'h0080, 16'h0, 100, 16'h0, 1'b0);
    chk("t4_err", bus_err, 1); chk("t4_mdr", mdr, 16'hFFFF);
    // T5: beat while busy dropped
    cmd(2'b01, 1'b1, 16'h0060, 16'h0, 16'h0, 3, 16'h3333, 1'b1);
    cmd(2'b00, 1'b0, 16'h0, 16'h0, 16'h4242, 1, 16'h0, 1'b0);
    // T6: reset mid-read, ack afterwards ignored
    beat = 1'b1; rec = 2'b01; pc = 16'h0070; step();
    beat = 1'b0; rec = 2'b00;
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    chk("t6_req_now", mem_req, 0);
    mem_ack = 1'b1; mem_rdata = 16'h4444; step(); mem_ack = 1'b0;
    chk("t6_req", mem_req, 0); chk("t6_stall", stall, 0);
    chk("t6_mdr", mdr, 0); chk("t6_err", bus_err, 0);
    // randomized commands
    for (int i = 0; i < 60; i++) begin
      logic [1:0] r;
      logic       w;
      int         d;
      r = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 4));
      cmd(r, w, AW'($urandom), DW'($urandom), DW'($urandom), d, DW'($urandom),
          ($urandom_range(0, 3) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global bound in case the design never returns to idle
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
